// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types and constants for the data-memory bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  typedef enum logic {
    ARB       = 1'b0,
    LOCKED_M1 = 1'b1
  } arb_state_e;

  // Read latency of block RAM, in cycles from grant to data
  localparam int unsigned BSRAM_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : Two-master / one-slave data-memory bus bundle. The m1_lock wire
//           exists only when DMEM_ARB_LOCK_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;

  logic        m0_req;
  logic [3:0]  m0_Write;
  logic [31:0] m0_Addr;
  logic [31:0] m0_WData;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_RData;

  logic        m1_req;
  logic [3:0]  m1_Write;
  logic [31:0] m1_Addr;
  logic [31:0] m1_WData;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_RData;
`ifdef DMEM_ARB_LOCK_EN
  logic        m1_lock;
`endif

  logic [3:0]  s_Write;
  logic [31:0] s_Addr;
  logic [31:0] s_WData;
  logic [31:0] s_RData;

  // Arbiter side
  modport slave (
`ifdef DMEM_ARB_LOCK_EN
    input  m1_lock,
`endif
    input  m0_req, m0_Write, m0_Addr, m0_WData,
    input  m1_req, m1_Write, m1_Addr, m1_WData,
    input  s_RData,
    output m0_gnt, m0_rvalid, m0_RData,
    output m1_gnt, m1_rvalid, m1_RData,
    output s_Write, s_Addr, s_WData
  );

  // Requesters and memory side
  modport master (
`ifdef DMEM_ARB_LOCK_EN
    output m1_lock,
`endif
    output m0_req, m0_Write, m0_Addr, m0_WData,
    output m1_req, m1_Write, m1_Addr, m1_WData,
    output s_RData,
    input  m0_gnt, m0_rvalid, m0_RData,
    input  m1_gnt, m1_rvalid, m1_RData,
    input  s_Write, s_Addr, s_WData
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin grant with a registered last-grant pointer.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] i_req,
  output logic      [1:0] o_gnt
);

  owner_e r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (!rst) begin
      if (i_req == 2'b11) begin
        o_gnt = (r_last == OWNER_M1) ? 2'b01 : 2'b10;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  // Reset to M1 so M0 wins the first contested cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= OWNER_M1;
    end else if (o_gnt[0]) begin
      r_last <= OWNER_M0;
    end else if (o_gnt[1]) begin
      r_last <= OWNER_M1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Shares one data-memory port between two masters; optional master-1
//           bus lock when DMEM_ARB_LOCK_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEMORY_TYPE = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned c_RD_LAT = (MEMORY_TYPE != 0) ? BSRAM_LAT : 32'd0;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_m0_block;
  logic       w_rd;
  logic       w_rv_any;
  owner_e     w_win;
  owner_e     w_rv_owner;

  assign w_req = {bus.m1_req, bus.m0_req & ~w_m0_block};

  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

`ifdef DMEM_ARB_LOCK_EN
  arb_state_e r_state;

  // Once the lock drops, m0 is unmasked in that very cycle
  assign w_m0_block = (r_state == LOCKED_M1) && bus.m1_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      case (r_state)
        ARB:       if (w_gnt[1] && bus.m1_lock) r_state <= LOCKED_M1;
        LOCKED_M1: if (!bus.m1_lock)            r_state <= ARB;
        default:   r_state <= ARB;
      endcase
    end
  end
`else
  assign w_m0_block = 1'b0;
`endif

  assign bus.m0_gnt = w_gnt[0];
  assign bus.m1_gnt = w_gnt[1];
  assign w_win      = w_gnt[1] ? OWNER_M1 : OWNER_M0;

  always_comb begin
    bus.s_Write = 4'b0000;
    bus.s_Addr  = 32'h0;
    bus.s_WData = 32'h0;
    if (w_gnt[0]) begin
      bus.s_Write = bus.m0_Write;
      bus.s_Addr  = bus.m0_Addr;
      bus.s_WData = bus.m0_WData;
    end else if (w_gnt[1]) begin
      bus.s_Write = bus.m1_Write;
      bus.s_Addr  = bus.m1_Addr;
      bus.s_WData = bus.m1_WData;
    end
  end

  assign w_rd = (w_gnt != 2'b00) && (bus.s_Write == 4'b0000);

  generate
    if (c_RD_LAT != 0) begin : g_bsram
      logic   r_rd_pend;
      owner_e r_rd_owner;

      // Only the previous cycle's grant matters, so back-to-back reads
      // return in order without a deeper queue.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_pend  <= 1'b0;
          r_rd_owner <= OWNER_M0;
        end else begin
          r_rd_pend  <= w_rd;
          r_rd_owner <= w_win;
        end
      end

      assign w_rv_any   = r_rd_pend && !rst;
      assign w_rv_owner = r_rd_owner;
    end else begin : g_comb
      assign w_rv_any   = w_rd;
      assign w_rv_owner = w_win;
    end
  endgenerate

  assign bus.m0_rvalid = w_rv_any && (w_rv_owner == OWNER_M0);
  assign bus.m1_rvalid = w_rv_any && (w_rv_owner == OWNER_M1);
  assign bus.m0_RData  = bus.m0_rvalid ? bus.s_RData : 32'h0;
  assign bus.m1_RData  = bus.m1_rvalid ? bus.s_RData : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench: vector table, scoreboarded streaming reads,
//           reset and latency-0 corner cases.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus0 ();

  dmem_arbiter #(.MEMORY_TYPE(1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  dmem_arbiter #(.MEMORY_TYPE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [31:0] srd);
    bus.m0_req = r0; bus.m0_Write = w0; bus.m0_Addr = a0; bus.m0_WData = d0;
    bus.m1_req = r1; bus.m1_Write = w1; bus.m1_Addr = a1; bus.m1_WData = d1;
    bus.s_RData = srd;
  endtask

  typedef struct {
    logic r0; logic [3:0] w0; logic [31:0] a0; logic [31:0] d0;
    logic r1; logic [3:0] w1; logic [31:0] a1; logic [31:0] d1;
    logic [31:0] srd;
    logic g0; logic g1; logic rv0; logic rv1;
    logic [3:0] sw; logic [31:0] sa; logic [31:0] swd;
  } vec_t;

  typedef struct {
    logic owner;
    int   due;
  } sb_t;

  vec_t        vt[11];
  sb_t         sb_q[$];
  sb_t         sb_e;
  logic        exp_last;
  logic [1:0]  eg;
  logic        erv0, erv1, r1;
  logic [31:0] srd;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            r0    w0     a0            d0          r1    w1     a1            d1           srd            g0    g1    rv0   rv1   sw     sa            swd
    vt[0]  = '{1'b1, 4'h0, 32'h1000_0000, 32'h0,       1'b1, 4'h0, 32'h1000_0004, 32'h0,       32'h1111_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1000_0000, 32'h0};
    vt[1]  = '{1'b0, 4'h0, 32'h0,         32'h0,       1'b1, 4'h0, 32'h1000_0004, 32'h0,       32'h2222_0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0};
    vt[2]  = '{1'b0, 4'h0, 32'h0,         32'h0,       1'b0, 4'h0, 32'h0,         32'h0,       32'h3333_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0,         32'h0};
    vt[3]  = '{1'b0, 4'h0, 32'h0,         32'h0,       1'b1, 4'h3, 32'h1100_0000, 32'h0000_A5A5, 32'h4444_0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h1100_0000, 32'h0000_A5A5};
    vt[4]  = '{1'b0, 4'h0, 32'h0,         32'h0,       1'b0, 4'h0, 32'h0,         32'h0,       32'h5555_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0};
    vt[5]  = '{1'b1, 4'h0, 32'h1000_0008, 32'h0,       1'b1, 4'h0, 32'h1000_000C, 32'h0,       32'h6666_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1000_0008, 32'h0};
    vt[6]  = '{1'b1, 4'h0, 32'h1000_0010, 32'h0,       1'b1, 4'h0, 32'h1000_000C, 32'h0,       32'h7777_0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h1000_000C, 32'h0};
    vt[7]  = '{1'b1, 4'h0, 32'h1000_0010, 32'h0,       1'b1, 4'h0, 32'h1000_0014, 32'h0,       32'h8888_0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h1000_0010, 32'h0};
    vt[8]  = '{1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'h1000_0014, 32'h0,     32'h9999_0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h1000_0014, 32'h0};
    vt[9]  = '{1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0,       32'h0,       32'hAAAA_0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF};
    vt[10] = '{1'b0, 4'h0, 32'h0,         32'h0,       1'b0, 4'h0, 32'h0,         32'h0,       32'hBBBB_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0};

`ifdef DMEM_ARB_LOCK_EN
    bus.m1_lock = 1'b0;
    bus0.m1_lock = 1'b0;
`endif
    bus0.m0_req = 1'b0; bus0.m0_Write = 4'h0; bus0.m0_Addr = 32'h0; bus0.m0_WData = 32'h0;
    bus0.m1_req = 1'b0; bus0.m1_Write = 4'h0; bus0.m1_Addr = 32'h0; bus0.m1_WData = 32'h0;
    bus0.s_RData = 32'h0;

    // Reset with both masters requesting: nothing may be granted
    rst = 1'b1;
    drive(1'b1, 4'h0, 32'h1000_0000, 32'h0, 1'b1, 4'h0, 32'h1000_0004, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst gnt0",   {31'b0, bus.m0_gnt},    32'h0);
    chk("rst gnt1",   {31'b0, bus.m1_gnt},    32'h0);
    chk("rst rv0",    {31'b0, bus.m0_rvalid}, 32'h0);
    chk("rst rv1",    {31'b0, bus.m1_rvalid}, 32'h0);
    chk("rst sAddr",  bus.s_Addr,             32'h0);
    chk("rst sWrite", {28'b0, bus.s_Write},   32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].srd);
      #2;
      chk($sformatf("v%0d gnt0", i),   {31'b0, bus.m0_gnt},    {31'b0, vt[i].g0});
      chk($sformatf("v%0d gnt1", i),   {31'b0, bus.m1_gnt},    {31'b0, vt[i].g1});
      chk($sformatf("v%0d rv0", i),    {31'b0, bus.m0_rvalid}, {31'b0, vt[i].rv0});
      chk($sformatf("v%0d rv1", i),    {31'b0, bus.m1_rvalid}, {31'b0, vt[i].rv1});
      chk($sformatf("v%0d RData0", i), bus.m0_RData, vt[i].rv0 ? vt[i].srd : 32'h0);
      chk($sformatf("v%0d RData1", i), bus.m1_RData, vt[i].rv1 ? vt[i].srd : 32'h0);
      chk($sformatf("v%0d sWrite", i), {28'b0, bus.s_Write},   {28'b0, vt[i].sw});
      chk($sformatf("v%0d sAddr", i),  bus.s_Addr,  vt[i].sa);
      chk($sformatf("v%0d sWData", i), bus.s_WData, vt[i].swd);
    end

    // m0 requests continuously, m1 joins at cycle 2; last grant was to M0
    exp_last = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      r1  = (c >= 2) && (c < 12);
      srd = 32'hC0DE_0000 | c;
      drive(c < 12, 4'h0, 32'h0000_0300, 32'h0, r1, 4'h0, 32'h0000_0400, 32'h0, srd);
      if (c >= 12)  eg = 2'b00;
      else if (r1)  eg = exp_last ? 2'b01 : 2'b10;
      else          eg = 2'b01;
      #2;
      chk($sformatf("rr%0d gnt0", c), {31'b0, bus.m0_gnt}, {31'b0, eg[0]});
      chk($sformatf("rr%0d gnt1", c), {31'b0, bus.m1_gnt}, {31'b0, eg[1]});
      chk($sformatf("rr%0d sAddr", c), bus.s_Addr,
          eg[1] ? 32'h0000_0400 : (eg[0] ? 32'h0000_0300 : 32'h0));
      erv0 = 1'b0;
      erv1 = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due == c) begin
        sb_e = sb_q.pop_front();
        if (sb_e.owner) erv1 = 1'b1;
        else            erv0 = 1'b1;
      end
      chk($sformatf("rr%0d rv0", c),    {31'b0, bus.m0_rvalid}, {31'b0, erv0});
      chk($sformatf("rr%0d rv1", c),    {31'b0, bus.m1_rvalid}, {31'b0, erv1});
      chk($sformatf("rr%0d RData0", c), bus.m0_RData, erv0 ? srd : 32'h0);
      chk($sformatf("rr%0d RData1", c), bus.m1_RData, erv1 ? srd : 32'h0);
      if (eg != 2'b00) begin
        sb_q.push_back('{owner: eg[1], due: c + 1});
        exp_last = eg[1];
      end
    end
    chk("rr sb drained", sb_q.size(), 32'd0);

    // Read granted, then reset the next cycle: pending read is dropped
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h0000_0500, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5A5A_5A5A);
    #2;
    chk("rmid gnt0", {31'b0, bus.m0_gnt}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'h0, 32'h0000_0504, 32'h0, 1'b1, 4'h0, 32'h0000_0508, 32'h0, 32'h6B6B_6B6B);
    #2;
    chk("rmid rv0",    {31'b0, bus.m0_rvalid}, 32'h0);
    chk("rmid RData0", bus.m0_RData,           32'h0);
    chk("rmid gnt0r",  {31'b0, bus.m0_gnt},    32'h0);
    chk("rmid gnt1r",  {31'b0, bus.m1_gnt},    32'h0);
    chk("rmid sAddr",  bus.s_Addr,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post rst gnt0", {31'b0, bus.m0_gnt},    32'h1);
    chk("post rst gnt1", {31'b0, bus.m1_gnt},    32'h0);
    chk("post rst rv0",  {31'b0, bus.m0_rvalid}, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);

    // Zero-latency memory: data returns in the grant cycle
    bus0.m0_req = 1'b1; bus0.m0_Addr = 32'h0000_0040; bus0.s_RData = 32'h1234_5678;
    #2;
    chk("mt0 gnt0",   {31'b0, bus0.m0_gnt},    32'h1);
    chk("mt0 rv0",    {31'b0, bus0.m0_rvalid}, 32'h1);
    chk("mt0 RData0", bus0.m0_RData,           32'h1234_5678);
    chk("mt0 rv1",    {31'b0, bus0.m1_rvalid}, 32'h0);
    @(negedge clk);
    bus0.m0_req = 1'b0; bus0.m1_req = 1'b1; bus0.m1_Write = 4'h1; bus0.s_RData = 32'h8765_4321;
    #2;
    chk("mt0 wr gnt1", {31'b0, bus0.m1_gnt},    32'h1);
    chk("mt0 wr rv1",  {31'b0, bus0.m1_rvalid}, 32'h0);
    @(negedge clk);
    bus0.m1_req = 1'b0; bus0.m1_Write = 4'h0;

`ifdef DMEM_ARB_LOCK_EN
    @(negedge clk);
    bus.m1_lock = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0600, 32'h0, 32'h0);
    #2;
    chk("lock take gnt1", {31'b0, bus.m1_gnt}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 32'h0000_0700, 32'h0, 1'b1, 4'h0, 32'h0000_0604, 32'h0, 32'h0);
      #2;
      chk($sformatf("lock%0d gnt0", c), {31'b0, bus.m0_gnt}, 32'h0);
      chk($sformatf("lock%0d gnt1", c), {31'b0, bus.m1_gnt}, 32'h1);
    end
    @(negedge clk);
    bus.m1_lock = 1'b0;
    drive(1'b1, 4'h0, 32'h0000_0700, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("unlock gnt0", {31'b0, bus.m0_gnt}, 32'h1);
    chk("unlock sAddr", bus.s_Addr, 32'h0000_0700);
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data-memory bus port (the memmux master side) between the core data port (master 0) and a secondary bus master such as a loader or DMA engine (master 1). It grants at most one transfer per cycle using round-robin arbitration and steers the slave-side strobes, address and write data from the winner. It returns read data to the master that issued the read, matching the one-cycle read latency of BSRAM or the zero-cycle latency of synthesized memory.

## Interface
Parameters:
- MEMORY_TYPE, default 1: 1 = BSRAM, read data one cycle after grant; 0 = synthesized memory, read data in the grant cycle.

Ports:
- clk  in  1  bus clock (dmem clock domain).
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- m0_req / m1_req  in  1  transfer request; held stable with its payload until granted.
- m0_Write / m1_Write  in  4  byte write strobes; 4'b0000 = read.
- m0_Addr / m1_Addr  in  32  byte address.
- m0_WData / m1_WData  in  32  write data.
- m0_gnt / m1_gnt  out  1  transfer accepted this cycle.
- m0_rvalid / m1_rvalid  out  1  read data valid for that master.
- m0_RData / m1_RData  out  32  read data; 0 when the matching rvalid is low.
- s_Write  out  4  slave strobes; 0 when idle.
- s_Addr, s_WData  out  32  slave address and write data; 0 when idle.
- s_RData  in  32  slave read data.
- m1_lock  in  1  present only with DMEM_ARB_LOCK_EN (see Configuration).

## Operation
- Each cycle, select the winner from the asserted requests. With a single request, that master wins. With both requests, the master not granted most recently wins. The registered pointer last_gnt updates only on a grant.
- Drive the winner's gnt high and route its Write/Addr/WData to s_*. With no winner, s_* is 0.
- A write completes in its grant cycle. Writes produce no rvalid.
- A read is granted when Write == 0.
  - MEMORY_TYPE=1: register rd_pend=1 and rd_owner=winner. In the next cycle, assert rvalid to rd_owner with RData = s_RData.
  - MEMORY_TYPE=0: assert rvalid in the grant cycle.
- Grants may be issued back to back. rd_pend/rd_owner track only the previous cycle's grant, so alternating reads M0, M1, M0 return data on consecutive cycles to the correct owners.
- State machine with lock (macro enabled): states ARB and LOCKED_M1.
  - ARB → LOCKED_M1 when m1 is granted while m1_lock=1.
  - In LOCKED_M1, only m1 can be granted; m0_gnt stays 0.
  - LOCKED_M1 → ARB on the first cycle m1_lock=0. Arbitration resumes that same cycle with last_gnt=M1, so a pending m0 wins.
- Reset values:
  - All gnt, rvalid, RData and s_* outputs are 0.
  - last_gnt=M1, so M0 has priority on the first contested cycle.
  - rd_pend=0 and the state is ARB.

## Timing
- gnt and s_* are combinational from req, last_gnt and state, with zero latency. rvalid/RData are combinational from rd_pend/rd_owner and s_RData.
- Read latency from grant to rvalid: 1 cycle with MEMORY_TYPE=1, 0 cycles with MEMORY_TYPE=0. Write latency: 0 cycles.
- Throughput: one transfer per cycle total. Under contention each master gets every second cycle.
- Reset asserted while a read is pending: rd_pend clears, no rvalid is issued, and the lock is released.
- While rst=1, gnt is forced to 0 regardless of req.
- A request deasserted without a grant is legal and leaves no side effects.

## Configuration
- DMEM_ARB_LOCK_EN defined: the m1_lock port and the LOCKED_M1 state exist, giving master 1 atomic multi-cycle sequences.
- DMEM_ARB_LOCK_EN undefined: no m1_lock port, the FSM reduces to pure round-robin, and m0 is never starved for more than one cycle.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum owner_e {OWNER_M0, OWNER_M1};
  - typedef enum arb_state_e {ARB, LOCKED_M1};
  - localparam BSRAM_LAT = 1.
- Sub-module rr_arb2: a 2-way round-robin grant with a registered last-grant pointer. The top level adds payload steering, read-return tracking and the lock FSM.

## Test plan
- After reset, both masters request reads (m0 Addr 0x10000000, m1 Addr 0x10000004), MEMORY_TYPE=1 → m0_gnt in cycle 0, m1_gnt in cycle 1. m0_rvalid in cycle 1 and m1_rvalid in cycle 2, each carrying the s_RData of that cycle.
- m0_req held high continuously, m1 raises a read → m1_gnt within 1 cycle, then grants alternate M0/M1 each cycle.
- m1 alone writes Write=4'b0011, Addr 0x11000000, WData 0xA5A5 → same cycle s_Write=0011, s_Addr=0x11000000, m1_gnt=1. No rvalid on any later cycle.
- With lock: m1 granted with m1_lock=1, m0_req held for 5 cycles → m0_gnt=0 throughout. After m1_lock falls, m0_gnt=1 in that same cycle.
- A read granted in cycle n, then rst=1 in cycle n+1 → m0_rvalid=0, all outputs 0. After rst falls, contested requests go to m0 first.
- MEMORY_TYPE=0, m0 reads → m0_rvalid=1 in the grant cycle with m0_RData = s_RData.
